// File: rtl/level_detect_pkg.sv
// Shared types and defaults for the level_detect block.
package level_detect_pkg;

  // Debounced-level FSM states.
  typedef enum logic [1:0] {
    LOW    = 2'd0,
    ARM    = 2'd1,
    HIGH   = 2'd2,
    DISARM = 2'd3
  } state_t;

  localparam int DUR_W_DEFAULT = 16;

endpackage

// File: rtl/level_detect_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used to count the valid samples spanned by a high episode.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/level_detect.sv
// Hysteresis level detector with debounce for the moving-average FIR output.
// A sample is "above" when x >= th_hi and "below" when x < th_lo; a state
// change needs DEB consecutive qualifying valid samples. Invalid samples
// freeze everything.
// Optional build macro LEVEL_DETECT_PEAK_EN adds a 'peak' output holding the
// largest sample seen in the last completed high episode.
module level_detect
  import level_detect_pkg::*;
#(
  parameter int bW    = 8,
  parameter int DEB   = 4,
  parameter int DUR_W = DUR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [bW-1:0]    x,
  input  logic             x_vld,
  input  logic [bW-1:0]    th_hi,
  input  logic [bW-1:0]    th_lo,
  output logic             level,
  output logic             rise,
  output logic             fall,
`ifdef LEVEL_DETECT_PEAK_EN
  output logic [DUR_W-1:0] dur,
  output logic [bW-1:0]    peak
`else
  output logic [DUR_W-1:0] dur
`endif
);

  localparam int CNT_W = $clog2(DEB + 1);
  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEB);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             above, below;
  logic             in_high, nxt_high;
  logic             rise_d, fall_d;
  logic             ep_clr, ep_inc;
  logic [DUR_W-1:0] ep_cnt;
  logic [DUR_W-1:0] ep_final;

  assign above   = (x >= th_hi);
  assign below   = (x < th_lo);
  assign cnt_inc = cnt + ONE_C;

  // The completed episode includes the sample that closes it; keep saturation.
  assign ep_final = (ep_cnt == '1) ? ep_cnt : ep_cnt + DUR_W'(1);

  // Episode length: restarted on entry to HIGH, counts every valid high-side sample.
  sat_counter #(.W(DUR_W)) u_ep_cnt (
    .clk (clk),
    .rst (rst),
    .clr (ep_clr),
    .inc (ep_inc),
    .q   (ep_cnt)
  );

  // State register plus the registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: all flops use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state <= LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      dur   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= nxt_high;
      rise  <= rise_d;
      fall  <= fall_d;
      if (fall_d) dur <= ep_final;
    end
  end

  // Next-state and debounce-count logic; nothing moves without x_vld.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    if (x_vld) begin
      unique case (state)
        LOW: begin
          if (above) begin
            if (DEB == 1) begin
              state_nxt = HIGH;
              cnt_nxt   = '0;
            end else begin
              state_nxt = ARM;
              cnt_nxt   = ONE_C;
            end
          end
        end
        ARM: begin
          if (!above) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end else if (cnt_inc == DEB_C) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt_inc;
          end
        end
        HIGH: begin
          if (below) begin
            if (DEB == 1) begin
              state_nxt = LOW;
              cnt_nxt   = '0;
            end else begin
              state_nxt = DISARM;
              cnt_nxt   = ONE_C;
            end
          end
        end
        DISARM: begin
          if (!below) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else if (cnt_inc == DEB_C) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt_inc;
          end
        end
        default: begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode: edges of the high/low partition drive the event pulses.
  always_comb begin
    in_high  = (state == HIGH) || (state == DISARM);
    nxt_high = (state_nxt == HIGH) || (state_nxt == DISARM);
    rise_d   = !in_high && nxt_high;
    fall_d   = in_high && !nxt_high;
    ep_clr   = rise_d;
    ep_inc   = x_vld && in_high;
  end

`ifdef LEVEL_DETECT_PEAK_EN
  logic [bW-1:0] run_max;

  // Running maximum over the current episode, published alongside dur.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_max <= '0;
      peak    <= '0;
    end else begin
      if (rise_d) begin
        run_max <= x;
      end else if (ep_inc && (x > run_max)) begin
        run_max <= x;
      end
      if (fall_d) peak <= (x > run_max) ? x : run_max;
    end
  end
`endif

endmodule

// File: tb/tb_level_detect.sv
// Directed self-checking bench for level_detect (DEB=4, th_hi=100, th_lo=50).
module tb_level_detect;

  localparam int BW    = 8;
  localparam int DEB   = 4;
  localparam int DUR_W = 16;

  logic             clk;
  logic             rst;
  logic [BW-1:0]    x;
  logic             x_vld;
  logic [BW-1:0]    th_hi;
  logic [BW-1:0]    th_lo;
  logic             level;
  logic             rise;
  logic             fall;
  logic [DUR_W-1:0] dur;
`ifdef LEVEL_DETECT_PEAK_EN
  logic [BW-1:0]    peak;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  level_detect #(.bW(BW), .DEB(DEB), .DUR_W(DUR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .x_vld (x_vld),
    .th_hi (th_hi),
    .th_lo (th_lo),
    .level (level),
    .rise  (rise),
    .fall  (fall),
`ifdef LEVEL_DETECT_PEAK_EN
    .dur   (dur),
    .peak  (peak)
`else
    .dur   (dur)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one sample on the falling edge; outputs are inspected just after the next rising edge.
  task automatic send(input logic [BW-1:0] xv, input logic vld);
    @(negedge clk);
    rst   = 1'b0;
    x     = xv;
    x_vld = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic send_n(input logic [BW-1:0] xv, input int n);
    for (int i = 0; i < n; i++) send(xv, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    x_vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    x     = '0;
    x_vld = 1'b0;
    th_hi = 8'd100;
    th_lo = 8'd50;
    repeat (2) @(posedge clk);
    #1;
    check("reset_level", level, 0);
    check("reset_rise",  rise,  0);
    check("reset_fall",  fall,  0);
    check("reset_dur",   dur,   0);

    // Clean rise
    send_n(8'd120, 3);
    check("clean_no_early_rise", rise, 0);
    check("clean_level_low", level, 0);
    send(8'd120, 1'b1);
    check("clean_rise", rise, 1);
    check("clean_level", level, 1);
    send(8'd120, 1'b1);
    check("clean_rise_one_cycle", rise, 0);
    check("clean_level_hold", level, 1);

    // Glitch rejection
    do_reset();
    send_n(8'd120, 3);
    send(8'd80, 1'b1);
    check("glitch_no_rise", rise, 0);
    check("glitch_level", level, 0);
    send_n(8'd120, 3);
    check("glitch_restart_no_rise", rise, 0);
    send(8'd120, 1'b1);
    check("glitch_rise", rise, 1);

    // Valid gaps
    do_reset();
    send(8'd120, 1'b1);
    send(8'd120, 1'b0);
    send(8'd120, 1'b1);
    send(8'd120, 1'b0);
    send(8'd120, 1'b1);
    send(8'd120, 1'b0);
    check("gaps_no_rise", rise, 0);
    check("gaps_level_low", level, 0);
    send(8'd120, 1'b1);
    check("gaps_rise", rise, 1);
    send(8'd120, 1'b0);
    check("gaps_rise_cleared", rise, 0);
    check("gaps_level_hold", level, 1);

    // Full episode with hysteresis
    do_reset();
    send_n(8'd120, 4);
    check("ep_rise", rise, 1);
    send_n(8'd80, 6);
    check("ep_hyst_level", level, 1);
    check("ep_hyst_no_fall", fall, 0);
    send_n(8'd30, 3);
    check("ep_no_early_fall", fall, 0);
    check("ep_level_still_high", level, 1);
    send(8'd30, 1'b1);
    check("ep_fall", fall, 1);
    check("ep_rise_not_with_fall", rise, 0);
    check("ep_level_low", level, 0);
    check("ep_dur", dur, 10);
    send(8'd30, 1'b1);
    check("ep_fall_one_cycle", fall, 0);

    // Re-enter HIGH: dur holds, then reset mid-episode
    send_n(8'd120, 4);
    check("rehigh_rise", rise, 1);
    check("rehigh_dur_hold", dur, 10);
    send_n(8'd120, 2);
    do_reset();
    check("rst_mid_level", level, 0);
    check("rst_mid_fall", fall, 0);
    check("rst_mid_dur", dur, 0);
    send(8'd30, 1'b1);
    check("rst_mid_no_late_fall", fall, 0);
    send_n(8'd120, 4);
    check("post_rst_rise", rise, 1);

    // Threshold boundaries: x == th_lo is not below, x == th_hi is above
    send_n(8'd50, 4);
    check("bound_lo_no_fall", fall, 0);
    check("bound_lo_level", level, 1);
    send_n(8'd49, 4);
    check("bound_lo_fall", fall, 1);
    check("bound_dur", dur, 8);
    do_reset();
    send_n(8'd100, 4);
    check("bound_hi_rise", rise, 1);

`ifdef LEVEL_DETECT_PEAK_EN
    // Peak capture
    do_reset();
    check("peak_reset", peak, 0);
    send_n(8'd120, 4);
    send(8'd120, 1'b1);
    send(8'd200, 1'b1);
    send(8'd90, 1'b1);
    send_n(8'd30, 4);
    check("peak_fall", fall, 1);
    check("peak_dur", dur, 7);
    check("peak_val", peak, 200);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
